temp_avg_monitor: RTL and testbench

//  Sequential, parametrised successor to the 4-sensor combinational averager.

---
 rtl/temp_avg_monitor.sv | 105 ++++++++++
 tb/tb_temp_avg_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_avg_monitor.sv
// Serial N-channel temperature averager with a qualified, hysteretic over-temperature flag.
// One snapshot is taken per handshake, summed over N cycles with one adder, then averaged.
module temp_avg_monitor #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int LOG2N = 2,
  parameter int HYST  = 2,
  parameter int HOLD  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] temps,
  input  logic [W-1:0]   temp_compare,
  output logic [W-1:0]   avg,
  output logic           avg_valid,
  output logic           too_hot
);

  localparam int SW  = W + LOG2N;
  localparam int HCW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [N*W-1:0]   temps_lat;
  logic [W-1:0]     thr_lat;
  logic [SW-1:0]    sum;
  logic [LOG2N-1:0] cnt;
  logic [HCW-1:0]   hot_cnt;

  logic [W-1:0]     chan [N];
  logic [W-1:0]     avg_new;
  logic [W-1:0]     low;
  logic             over;
  logic             under;
  logic [HCW-1:0]   hot_cnt_inc;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = temps_lat[gi*W +: W];
    end
  endgenerate

  // Dividing by a power of two is a plain drop of the low LOG2N sum bits.
  assign avg_new     = sum[SW-1:LOG2N];
  assign low         = (thr_lat > W'(HYST)) ? thr_lat - W'(HYST) : '0;
  assign over        = avg_new > thr_lat;
  assign under       = avg_new < low;
  assign hot_cnt_inc = (hot_cnt >= HCW'(HOLD)) ? HCW'(HOLD) : hot_cnt + HCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      temps_lat <= '0;
      thr_lat   <= '0;
      sum       <= '0;
      cnt       <= '0;
      hot_cnt   <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      too_hot   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            temps_lat <= temps;
            thr_lat   <= temp_compare;
            sum       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          sum <= sum + SW'(chan[cnt]);
          cnt <= cnt + LOG2N'(1);
          if (cnt == LOG2N'(N - 1)) state <= DONE;
        end
        DONE: begin
          avg       <= avg_new;
          avg_valid <= 1'b1;
          // An equal average is not hot; clearing only happens below the band.
          if (over) begin
            hot_cnt <= hot_cnt_inc;
            if (hot_cnt_inc == HCW'(HOLD)) too_hot <= 1'b1;
          end else begin
            hot_cnt <= '0;
            if (under) too_hot <= 1'b0;
          end
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_avg_monitor.sv
// Directed and randomized checks of temp_avg_monitor against an arithmetic reference model.
module tb_temp_avg_monitor;
  localparam int W = 8, N = 4, LOG2N = 2, HYST = 2, HOLD = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] temps = '0;
  logic [W-1:0]   temp_compare = '0;
  logic [W-1:0]   avg;
  logic           avg_valid;
  logic           too_hot;

  int tests = 0;
  int fails = 0;

  // Reference state: qualification counter, flag and last average.
  int m_hc  = 0;
  int m_hot = 0;
  int m_avg = 0;

  typedef struct packed {
    logic [N*W-1:0] t;
    logic [W-1:0]   thr;
  } snap_t;

  temp_avg_monitor #(.W(W), .N(N), .LOG2N(LOG2N), .HYST(HYST), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .temps(temps), .temp_compare(temp_compare),
    .avg(avg), .avg_valid(avg_valid), .too_hot(too_hot)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic int ref_avg(input logic [N*W-1:0] t);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(t[i*W +: W]);
    return s / N;
  endfunction

  task automatic model_step(input logic [N*W-1:0] t, input int thr);
    int a, lo;
    a  = ref_avg(t);
    lo = (thr > HYST) ? thr - HYST : 0;
    if (a > thr) begin
      m_hc = (m_hc + 1 > HOLD) ? HOLD : m_hc + 1;
      if (m_hc == HOLD) m_hot = 1;
    end else begin
      m_hc = 0;
      if (a < lo) m_hot = 0;
    end
    m_avg = a;
  endtask

  task automatic rand_snap(output logic [N*W-1:0] t, output logic [W-1:0] thr);
    int base;
    base = int'($urandom_range(0, 249));
    t = pk(base + int'($urandom_range(0, 6)), base + int'($urandom_range(0, 6)),
           base + int'($urandom_range(0, 6)), base + int'($urandom_range(0, 6)));
    thr = W'(base + int'($urandom_range(0, 5)));
  endtask

  // One snapshot through a single handshake; scrambles inputs while busy.
  task automatic send(input logic [N*W-1:0] t, input logic [W-1:0] thr, input string tag);
    int c;
    int prev_avg, prev_hot;
    c = 0;
    while (!in_ready && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; temps = t; temp_compare = thr;
    @(posedge clk); #1;
    in_valid = 1'b0; temps = {$urandom}; temp_compare = W'($urandom);
    prev_avg = m_avg; prev_hot = m_hot;
    model_step(t, int'(thr));
    c = 0;
    while (!avg_valid && c < N + 4) begin
      check({tag, "_busy"}, {in_ready, too_hot, 22'd0, avg},
            {1'b0, 1'(prev_hot), 22'd0, W'(prev_avg)});
      @(posedge clk); #1; c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(N + 1));
    check({tag, "_avg"}, 32'(avg), 32'(m_avg));
    check({tag, "_hot"}, 32'(too_hot), 32'(m_hot));
    check({tag, "_ready_done"}, 32'(in_ready), 32'd1);
    $display("[TB] %s avg=%0d too_hot=%0d thr=%0d", tag, avg, too_hot, thr);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(avg_valid), 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] t;
    logic [W-1:0]   thr;
    snap_t          q[$];
    snap_t          s;
    int             done_n, cyc, last, seen;

    #12;
    check("reset_outputs", {in_ready, avg_valid, too_hot, 21'd0, avg}, {3'b100, 29'd0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Qualification: first hot average only arms the counter.
    send(pk(10, 20, 30, 40), 8'd20, "t1a");
    check("t1a_spec", {too_hot, 23'd0, avg}, {1'b0, 23'd0, 8'd25});
    send(pk(10, 20, 30, 40), 8'd20, "t1b");
    check("t1b_spec", 32'(too_hot), 32'd1);

    // Hysteresis band holds the flag; below the band clears it.
    send(pk(19, 19, 19, 19), 8'd20, "t2a");
    check("t2a_spec", 32'(too_hot), 32'd1);
    send(pk(17, 17, 17, 17), 8'd20, "t2b");
    check("t2b_spec", 32'(too_hot), 32'd0);

    // Full-scale sum and truncation.
    send(pk(255, 255, 255, 255), 8'd254, "t3a");
    check("t3a_spec", 32'(avg), 32'd255);
    send(pk(1, 1, 1, 2), 8'd254, "t3b");
    check("t3b_spec", 32'(avg), 32'd1);

    // Equality is not hot, so alternating never qualifies.
    for (int i = 0; i < 3; i++) begin
      send(pk(25, 25, 25, 25), 8'd20, "t4hot");
      check("t4hot_spec", 32'(too_hot), 32'd0);
      send(pk(20, 20, 20, 20), 8'd20, "t4eq");
      check("t4eq_spec", 32'(too_hot), 32'd0);
    end

    // in_valid held high: snapshots accepted back-to-back at max throughput.
    in_valid = 1'b1;
    done_n = 0; cyc = 0; last = -1;
    while (1) begin
      if (avg_valid) begin
        if (q.size() == 0) begin
          check("t5_queue", 32'd1, 32'd0);
        end else begin
          s = q.pop_front();
          model_step(s.t, int'(s.thr));
          check("t5_avg", 32'(avg), 32'(m_avg));
          check("t5_hot", 32'(too_hot), 32'(m_hot));
          $display("[TB] t5 avg=%0d too_hot=%0d cycle=%0d", avg, too_hot, cyc);
        end
        if (last >= 0) check("t5_gap", 32'(cyc - last), 32'(N + 2));
        last = cyc;
        done_n++;
      end
      if (done_n == 3 || cyc >= 60) break;
      rand_snap(t, thr);
      temps = t; temp_compare = thr;
      if (in_ready) q.push_back('{t: t, thr: thr});
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check("t5_done", 32'(done_n), 32'd3);

    // Reset during accumulation aborts cleanly.
    send(pk(30, 30, 30, 30), 8'd20, "t6pre_a");
    send(pk(30, 30, 30, 30), 8'd20, "t6pre_b");
    in_valid = 1'b1; temps = pk(50, 50, 50, 50); temp_compare = 8'd20;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("t6_reset_now", {in_ready, avg_valid, too_hot, 21'd0, avg}, {3'b100, 29'd0});
    @(negedge clk); rst_n = 1'b1;
    m_hc = 0; m_hot = 0; m_avg = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (avg_valid) seen++;
    end
    check("t6_no_pulse", 32'(seen), 32'd0);
    $display("[TB] t6 reset abort avg=%0d too_hot=%0d", avg, too_hot);
    send(pk(40, 44, 48, 52), 8'd30, "t6post");

    // Randomized snapshots near threshold.
    for (int i = 0; i < 40; i++) begin
      rand_snap(t, thr);
      send(t, thr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
